vpu_layer_composer: RTL and testbench

- Parametrised successor of the embedded VPU pixel composer. Merges NUM_LAYERS layer pixel streams (background, sprites, HUD) per pixel by fixed priority and colour-key transparency.
- Writes the resulting raster-order frame into the downstream video FIFO through a wrreq/wrfull handshake.
- Tracks x/y, flags the first pixel of each frame and pulses end-of-frame. Sits between the layer fetch units and the scan-out FIFO.

---
 rtl/vpu_layer_composer.sv | 143 ++++++++++++++
 tb/tb_vpu_layer_composer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_layer_composer.sv
// Layer composer: merges NUM_LAYERS pixel streams by priority/colour key into a raster frame for the video FIFO.
// Optional build macro VPU_COMPOSER_TEST_PATTERN_EN adds a colour-bar test pattern source.
module vpu_layer_composer #(
   parameter int COLOR_W    = 24,
   parameter int NUM_LAYERS = 4,
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int X_W        = 10,
   parameter int Y_W        = 9
) (
   input  logic                          clk_clk,
   input  logic                          reset_reset_n,
   input  logic                          enable,
   input  logic [NUM_LAYERS*COLOR_W-1:0] layer_pixel,
   input  logic [NUM_LAYERS-1:0]         layer_valid,
   output logic [NUM_LAYERS-1:0]         layer_ready,
   input  logic [COLOR_W-1:0]            transparent_key,
   input  logic [COLOR_W-1:0]            bg_color,
   output logic [COLOR_W-1:0]            pixel_out,
   output logic                          wrreq,
   input  logic                          wrfull,
   output logic                          new_frame,
   output logic                          frame_done,
   output logic [X_W-1:0]                x_pos,
   output logic [Y_W-1:0]                y_pos
`ifdef VPU_COMPOSER_TEST_PATTERN_EN
   ,
   input  logic                          test_pattern
`endif
);

   localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACTIVE - 1);

   typedef enum logic [1:0] {IDLE, GATHER, EMIT} state_t;

   state_t             state;
   state_t             state_next;
   logic               tp_mode;
   logic               take_pixel;
   logic               load_pixel;
   logic               line_end;
   logic               frame_end;
   logic [COLOR_W-1:0] composed;

   assign line_end  = (x_pos == X_LAST);
   assign frame_end = line_end && (y_pos == Y_LAST);

`ifdef VPU_COMPOSER_TEST_PATTERN_EN
   localparam int CH_W = COLOR_W / 3;

   logic [2:0]         bar;
   logic [COLOR_W-1:0] bar_pixel;

   assign bar       = x_pos[X_W-1 -: 3];
   assign bar_pixel = {{CH_W{bar[2]}}, {CH_W{bar[1]}}, {CH_W{bar[0]}}};

   // Pattern mode only changes between frames so a frame is never half bars, half layers.
   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         tp_mode <= 1'b0;
      end else if (state == IDLE || (wrreq && frame_end)) begin
         tp_mode <= test_pattern;
      end
   end
`else
   assign tp_mode = 1'b0;
`endif

   // Layers are consumed all together or not at all, keeping the streams aligned.
   always_comb begin
      take_pixel  = (state == GATHER) && (&layer_valid) && !tp_mode;
      load_pixel  = (state == GATHER) && (tp_mode || (&layer_valid));
      layer_ready = {NUM_LAYERS{take_pixel}};
      wrreq       = (state == EMIT) && !wrfull;
      new_frame   = wrreq && (x_pos == '0) && (y_pos == '0);
   end

   // Walk from lowest priority upwards so the lowest opaque index wins.
   always_comb begin
      composed = bg_color;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (layer_pixel[i*COLOR_W +: COLOR_W] != transparent_key) begin
            composed = layer_pixel[i*COLOR_W +: COLOR_W];
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (enable) begin
               state_next = GATHER;
            end
         end
         GATHER: begin
            if (load_pixel) begin
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (wrreq) begin
               if (frame_end) begin
                  state_next = enable ? GATHER : IDLE;
               end else begin
                  state_next = GATHER;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state      <= IDLE;
         x_pos      <= '0;
         y_pos      <= '0;
         pixel_out  <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         frame_done <= wrreq && frame_end;
         if (load_pixel) begin
`ifdef VPU_COMPOSER_TEST_PATTERN_EN
            pixel_out <= tp_mode ? bar_pixel : composed;
`else
            pixel_out <= composed;
`endif
         end
         if (wrreq) begin
            if (line_end) begin
               x_pos <= '0;
               y_pos <= frame_end ? '0 : y_pos + Y_W'(1);
            end else begin
               x_pos <= x_pos + X_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_vpu_layer_composer.sv
// Randomised self-checking bench for vpu_layer_composer on a small 4x2 frame with two layers.
module tb_vpu_layer_composer;

   localparam int CW = 24;
   localparam int NL = 2;
   localparam int H  = 4;
   localparam int V  = 2;
   localparam int XW = 3;
   localparam int YW = 2;
   localparam logic [CW-1:0] KEY = 24'hFF00FF;
   localparam logic [CW-1:0] BG  = 24'h000010;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             enable;
   logic [NL*CW-1:0] layer_pixel;
   logic [NL-1:0]    layer_valid;
   logic [NL-1:0]    layer_ready;
   logic [CW-1:0]    pixel_out;
   logic             wrreq;
   logic             wrfull;
   logic             new_frame;
   logic             frame_done;
   logic [XW-1:0]    x_pos;
   logic [YW-1:0]    y_pos;
   logic [CW-1:0]    l0;
   logic [CW-1:0]    l1;

   int checks = 0;
   int errors = 0;

   assign layer_pixel = {l1, l0};

   always #5 clk = ~clk;

   vpu_layer_composer #(
      .COLOR_W(CW), .NUM_LAYERS(NL), .H_ACTIVE(H), .V_ACTIVE(V), .X_W(XW), .Y_W(YW)
   ) dut (
      .clk_clk(clk),
      .reset_reset_n(reset_n),
      .enable(enable),
      .layer_pixel(layer_pixel),
      .layer_valid(layer_valid),
      .layer_ready(layer_ready),
      .transparent_key(KEY),
      .bg_color(BG),
      .pixel_out(pixel_out),
      .wrreq(wrreq),
      .wrfull(wrfull),
      .new_frame(new_frame),
      .frame_done(frame_done),
      .x_pos(x_pos),
      .y_pos(y_pos)
   );

   // Priority rule: first non-key layer from layer 0, else background.
   function automatic logic [CW-1:0] ref_pixel(input logic [CW-1:0] a, input logic [CW-1:0] b);
      if (a != KEY) return a;
      if (b != KEY) return b;
      return BG;
   endfunction

   function automatic logic [CW-1:0] rnd_px();
      if ($urandom_range(0, 3) == 0) return KEY;
      return CW'($urandom);
   endfunction

   task automatic set_layers(input int mode);
      case (mode)
         0: begin l0 = 24'h112233; l1 = 24'h445566; end
         1: begin l0 = KEY;        l1 = 24'h445566; end
         2: begin l0 = KEY;        l1 = KEY;        end
         default: begin l0 = rnd_px(); l1 = rnd_px(); end
      endcase
   endtask

   // Drives one full frame and checks every write against a queue of expected pixels.
   task automatic run_frame(input int mode, input int stall_at, input int stall_len,
                            input int gap_at, input int en_drop_at);
      logic [CW-1:0] q[$];
      logic [CW-1:0] exp_px;
      int  writes = 0;
      int  stall_cnt = 0;
      int  gap_cnt = 0;
      int  cyc = 0;
      int  pre;
      bit  need_new = 1'b1;
      bit  stalling;
      bit  gapping;
      while (writes < H*V && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (need_new) begin
            set_layers(mode);
            need_new = 1'b0;
         end
         stalling = (writes == stall_at) && (q.size() > 0) && (stall_cnt < stall_len);
         if (stalling) stall_cnt++;
         wrfull = stalling;
         gapping = (writes == gap_at) && (q.size() == 0) && (gap_cnt < 3);
         if (gapping) gap_cnt++;
         layer_valid = gapping ? 2'b01 : 2'b11;
         enable = !(en_drop_at >= 0 && writes >= en_drop_at);
         #1;
         pre = q.size();
         checks++;
         if (frame_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_done_mid: got %b expected 0 (write %0d)", frame_done, writes);
         end
         checks++;
         if (wrreq !== (pre > 0 && !wrfull)) begin
            errors++;
            $display("[TB] FAIL wrreq: got %b expected %b (write %0d, held %0d, full %b)",
                     wrreq, (pre > 0 && !wrfull), writes, pre, wrfull);
         end
         if (stalling) begin
            checks++;
            if (pixel_out !== q[0] || x_pos !== XW'(writes % H) || y_pos !== YW'(writes / H)) begin
               errors++;
               $display("[TB] FAIL stall_hold: got px %h (%0d,%0d) expected px %h (%0d,%0d)",
                        pixel_out, x_pos, y_pos, q[0], writes % H, writes / H);
            end
         end
         if (gapping) begin
            checks++;
            if (layer_ready !== 2'b00) begin
               errors++;
               $display("[TB] FAIL ready_partial_valid: got %b expected 00", layer_ready);
            end
         end
         if (layer_ready !== 2'b00) begin
            checks++;
            if (layer_ready !== 2'b11 || pre > 0) begin
               errors++;
               $display("[TB] FAIL ready_accept: got %b expected 00 or 11 with nothing held (held %0d)",
                        layer_ready, pre);
            end
            q.push_back(ref_pixel(l0, l1));
            need_new = 1'b1;
         end
         if (wrreq === 1'b1 && pre > 0) begin
            exp_px = q.pop_front();
            checks++;
            if (pixel_out !== exp_px) begin
               errors++;
               $display("[TB] FAIL pixel: got %h expected %h (write %0d)", pixel_out, exp_px, writes);
            end
            checks++;
            if (x_pos !== XW'(writes % H) || y_pos !== YW'(writes / H)) begin
               errors++;
               $display("[TB] FAIL position: got (%0d,%0d) expected (%0d,%0d)",
                        x_pos, y_pos, writes % H, writes / H);
            end
            checks++;
            if (new_frame !== (writes == 0)) begin
               errors++;
               $display("[TB] FAIL new_frame: got %b expected %b (write %0d)", new_frame, writes == 0, writes);
            end
            writes++;
         end
      end
      checks++;
      if (writes != H*V) begin
         errors++;
         $display("[TB] FAIL frame_timeout: got %0d writes expected %0d", writes, H*V);
      end
      @(posedge clk); #1;
      layer_valid = 2'b00;
      wrfull = 1'b0;
      #1;
      checks++;
      if (frame_done !== 1'b1 || x_pos !== '0 || y_pos !== '0 || layer_ready !== 2'b00) begin
         errors++;
         $display("[TB] FAIL frame_end: got done %b (%0d,%0d) ready %b expected done 1 (0,0) ready 00",
                  frame_done, x_pos, y_pos, layer_ready);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      enable = 1'b0;
      wrfull = 1'b0;
      layer_valid = 2'b11;
      l0 = 24'h112233;
      l1 = 24'h445566;
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (wrreq !== 1'b0) begin errors++; $display("[TB] FAIL reset_wrreq: got %b expected 0", wrreq); end
      checks++;
      if (layer_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 00", layer_ready); end
      checks++;
      if (new_frame !== 1'b0) begin errors++; $display("[TB] FAIL reset_new_frame: got %b expected 0", new_frame); end
      checks++;
      if (x_pos !== '0 || y_pos !== '0) begin errors++; $display("[TB] FAIL reset_pos: got (%0d,%0d) expected (0,0)", x_pos, y_pos); end
      checks++;
      if (pixel_out !== '0) begin errors++; $display("[TB] FAIL reset_pixel: got %h expected 000000", pixel_out); end
      checks++;
      if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frame_done); end
      @(posedge clk); #1;
      reset_n = 1'b1;
      #1;
      checks++;
      if (layer_ready !== 2'b00 || wrreq !== 1'b0) begin
         errors++;
         $display("[TB] FAIL idle_no_enable: got ready %b wrreq %b expected 00 0", layer_ready, wrreq);
      end
   endtask

   task automatic test_compose();
      run_frame(0, -1, 0, -1, -1);
      run_frame(1, -1, 0, -1, -1);
      run_frame(2, -1, 0, -1, -1);
      repeat (3) run_frame(3, -1, 0, -1, -1);
   endtask

   task automatic test_wrfull_stall();
      run_frame(3, 2, 5, -1, -1);
      run_frame(3, 5, 2, -1, -1);
   endtask

   task automatic test_valid_gap();
      run_frame(3, -1, 0, 1, -1);
   endtask

   task automatic test_back_to_back();
      run_frame(3, -1, 0, -1, -1);
      run_frame(3, 3, 1, -1, -1);
   endtask

   task automatic test_enable_drop();
      run_frame(0, -1, 0, -1, 1);
      repeat (4) begin
         @(posedge clk); #1;
         layer_valid = 2'b11;
         enable = 1'b0;
         #1;
         checks++;
         if (layer_ready !== 2'b00 || wrreq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_drop: got ready %b wrreq %b expected 00 0", layer_ready, wrreq);
         end
      end
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      int cyc = 0;
      while (seen < 5 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         enable = 1'b1;
         wrfull = 1'b0;
         layer_valid = 2'b11;
         set_layers(3);
         #1;
         if (wrreq === 1'b1) seen++;
      end
      checks++;
      if (seen != 5) begin
         errors++;
         $display("[TB] FAIL reset_mid_timeout: got %0d writes expected 5", seen);
      end
      @(posedge clk); #1;
      reset_n = 1'b0;
      enable = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      #1;
      checks++;
      if (x_pos !== '0 || y_pos !== '0 || pixel_out !== '0 || wrreq !== 1'b0 || layer_ready !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_mid: got (%0d,%0d) px %h wrreq %b ready %b expected (0,0) px 000000 0 00",
                  x_pos, y_pos, pixel_out, wrreq, layer_ready);
      end
      run_frame(3, -1, 0, -1, -1);
   endtask

   initial begin
      test_reset();
      test_compose();
      test_wrfull_stall();
      test_valid_gap();
      test_back_to_back();
      test_enable_drop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
